// File: rtl/seg_scan_if.sv
// Bus bundle for seg_scan_driver: segment write port, blanking, and scan outputs.
// The master drives the write/blank controls; the slave (the driver) returns the scan outputs.
interface seg_scan_if #(
    parameter int NDIG = 4
);
    localparam int SW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [7:0]      seg_in;
    logic [SW-1:0]   digit_sel;
    logic            load;
    logic            blank;
    logic [7:0]      seg_out;
    logic [NDIG-1:0] an_out;
    logic            frame;

    modport master (
        output seg_in, digit_sel, load, blank,
        input  seg_out, an_out, frame
    );

    modport slave (
        input  seg_in, digit_sel, load, blank,
        output seg_out, an_out, frame
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: NDIG digit registers shown one at a time,
// each for DIV cycles, with active-low one-hot anodes and a per-frame pulse.
module seg_scan_driver #(
    parameter int NDIG = 4,
    parameter int DIV  = 4
) (
    input  logic      clk,
    input  logic      reset,
    seg_scan_if.slave bus
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [NDIG-1:0][7:0] digits_q, digits_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [7:0]           seg_q, seg_d;
    logic [NDIG-1:0]      an_q, an_d;
    logic                 frame_q, frame_d;
    logic                 adv;

    always_comb begin
        digits_d = digits_q;
        if (bus.load && (int'(bus.digit_sel) < NDIG))
            digits_d[bus.digit_sel] = bus.seg_in;

        adv   = (cnt_q == CW'(DIV - 1));
        cnt_d = adv ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (adv)
            idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;

        // Outputs look ahead to the next index and the post-write registers,
        // so a live write shows up at the very edge that stores it.
        seg_d   = digits_d[idx_d];
        an_d    = bus.blank ? '1 : ~(NDIG'(1) << idx_d);
        frame_d = adv && (idx_q == IW'(NDIG - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            seg_q    <= 8'h00;
            an_q     <= '1;
            frame_q  <= 1'b0;
        end else begin
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.seg_out = seg_q;
    assign bus.an_out  = an_q;
    assign bus.frame   = frame_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a 4-digit/DIV=4 and a 3-digit/DIV=1 instance share
// one stimulus stream and are each checked every cycle against a timing model.
module tb_seg_scan_driver;
    logic       clk;
    logic       rst_n;
    logic [7:0] seg_in;
    logic [1:0] sel;
    logic       load;
    logic       blank;

    int total = 0;
    int bad   = 0;

    seg_scan_if #(.NDIG(4)) b4 ();
    seg_scan_if #(.NDIG(3)) b3 ();

    assign b4.seg_in = seg_in;  assign b4.digit_sel = sel;
    assign b4.load   = load;    assign b4.blank     = blank;
    assign b3.seg_in = seg_in;  assign b3.digit_sel = sel;
    assign b3.load   = load;    assign b3.blank     = blank;

    seg_scan_driver #(.NDIG(4), .DIV(4)) dut4 (.clk(clk), .reset(rst_n), .bus(b4));
    seg_scan_driver #(.NDIG(3), .DIV(1)) dut3 (.clk(clk), .reset(rst_n), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: k counts edges since reset release; the shown digit follows
    // directly from k, the frame pulse from k being a multiple of the frame length.
    int         k;
    logic [7:0] m4 [4];
    logic [7:0] m3 [3];
    logic [7:0] e4_seg, e3_seg;
    logic [3:0] e4_an;
    logic [2:0] e3_an;
    logic       e4_fr, e3_fr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            for (int i = 0; i < 4; i++) m4[i] = 8'h00;
            for (int i = 0; i < 3; i++) m3[i] = 8'h00;
            e4_seg = 8'h00; e4_an = 4'hF; e4_fr = 1'b0;
            e3_seg = 8'h00; e3_an = 3'h7; e3_fr = 1'b0;
        end else begin
            if (load) begin
                m4[sel] = seg_in;
                if (sel < 3) m3[sel] = seg_in;
            end
            k++;
            e4_seg = m4[(k / 4) % 4];
            e4_an  = blank ? 4'hF : ~(4'b0001 << ((k / 4) % 4));
            e4_fr  = (k % 16 == 0);
            e3_seg = m3[k % 3];
            e3_an  = blank ? 3'h7 : ~(3'b001 << (k % 3));
            e3_fr  = (k % 3 == 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (k=%0d)", nm, act, exp, k);
        end
    endtask

    always @(negedge clk) begin
        chk("seg4", 32'(b4.seg_out), 32'(e4_seg));
        chk("an4",  32'(b4.an_out),  32'(e4_an));
        chk("fr4",  32'(b4.frame),   32'(e4_fr));
        chk("seg3", 32'(b3.seg_out), 32'(e3_seg));
        chk("an3",  32'(b3.an_out),  32'(e3_an));
        chk("fr3",  32'(b3.frame),   32'(e3_fr));
    end

    task automatic run_to(input int target);
        while (k < target) @(negedge clk);
    endtask

    task automatic do_load(input logic [1:0] s, input logic [7:0] v);
        sel = s; seg_in = v; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; seg_in = 8'h00; sel = 2'd0; load = 1'b0; blank = 1'b0;
        #12;
        chk("rst_seg", 32'(b4.seg_out), 32'h00);
        chk("rst_an",  32'(b4.an_out),  32'hF);
        chk("rst_fr",  32'(b4.frame),   32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_an4", 32'(b4.an_out), 32'b1110);
        chk("first_an3", 32'(b3.an_out), 32'b101);

        // Free-running scan with the four patterns loaded
        do_load(2'd0, 8'h3F);
        do_load(2'd1, 8'h06);
        do_load(2'd2, 8'h5B);
        do_load(2'd3, 8'h4F);
        run_to(16);
        chk("frame16", 32'(b4.frame), 32'h1);
        chk("seg16",   32'(b4.seg_out), 32'h3F);
        @(negedge clk);
        chk("frame17", 32'(b4.frame), 32'h0);
        run_to(20);
        chk("an20",  32'(b4.an_out),  32'b1101);
        chk("seg20", 32'(b4.seg_out), 32'h06);
        run_to(28);
        chk("an28",  32'(b4.an_out),  32'b0111);
        chk("seg28", 32'(b4.seg_out), 32'h4F);

        // Live update of the displayed digit
        run_to(40);
        do_load(2'd2, 8'h7F);
        chk("live_seg", 32'(b4.seg_out), 32'h7F);
        chk("live_an",  32'(b4.an_out),  32'b1011);

        // Load landing on the advance edge
        run_to(51);
        do_load(2'd1, 8'h66);
        chk("adv_an",  32'(b4.an_out),  32'b1101);
        chk("adv_seg", 32'(b4.seg_out), 32'h66);

        // Blanking across a frame boundary
        run_to(59);
        blank = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("blank_an4", 32'(b4.an_out), 32'hF);
            chk("blank_an3", 32'(b3.an_out), 32'h7);
            if (k == 64) chk("blank_fr", 32'(b4.frame), 32'h1);
        end
        blank = 1'b0;
        @(negedge clk);
        chk("unblank_an",  32'(b4.an_out),  32'b1101);
        chk("unblank_seg", 32'(b4.seg_out), 32'h66);

        // Asynchronous reset between edges while digit 2 is shown
        run_to(72);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", 32'(b4.seg_out), 32'h00);
        chk("arst_an",  32'(b4.an_out),  32'hF);
        chk("arst_fr",  32'(b4.frame),   32'h0);
        chk("arst_an3", 32'(b3.an_out),  32'h7);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Out-of-range index on the 3-digit instance, right after restart
        do_load(2'd3, 8'hAA);
        chk("inv_an3a",  32'(b3.an_out),  32'b101);
        chk("inv_seg3a", 32'(b3.seg_out), 32'h00);
        chk("rs_an4",    32'(b4.an_out),  32'b1110);
        chk("rs_seg4",   32'(b4.seg_out), 32'h00);
        @(negedge clk);
        chk("inv_an3b",  32'(b3.an_out),  32'b011);
        chk("inv_seg3b", 32'(b3.seg_out), 32'h00);
        @(negedge clk);
        chk("inv_an3c",  32'(b3.an_out),  32'b110);
        chk("inv_seg3c", 32'(b3.seg_out), 32'h00);
        chk("inv_fr3",   32'(b3.frame),   32'h1);

        // Random traffic with occasional mid-cycle resets
        repeat (600) begin
            load   = 1'($urandom % 2);
            sel    = 2'($urandom % 4);
            seg_in = 8'($urandom);
            blank  = ($urandom % 8 == 0);
            if ($urandom % 97 == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        load = 1'b0; blank = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
